fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the update policy of the `pc` register. It drives that register's `pc_en`/`next_pc` inputs and runs the request/acknowledge handshake to instruction memory. It buffers up to two fetched instructions toward decode, and applies branch redirects and trap entry. It sits between `pc`, the instruction memory port, and the decode stage.

---
 rtl/fetch_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Drives the PC register update,
//               the imem request/ack handshake, a 2-deep fetch buffer toward
//               decode, and branch-redirect / trap-entry flushes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_en,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_pend_pc;

    logic        w_flush;
    logic [31:0] w_target;
    logic        w_consume;
    logic        w_slot_free;
    logic        w_out_load_mem;
    logic        w_out_load_skid;
    logic        w_skid_wr;
    logic        w_pend_wr;

    // The PC register owns the reset address; RESET_PC documents that contract.
    logic        w_unused_reset_pc;
    assign w_unused_reset_pc = ^RESET_PC;

    assign w_flush     = trap || redirect_valid;
    assign w_target    = trap ? TRAP_VEC : redirect_pc;
    assign w_consume   = r_if_valid && !stall;
    assign w_slot_free = !r_if_valid || w_consume;

    assign pc_en     = !rst;
    assign imem_addr = pc_cur;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: w_state_nxt = c_ST_REQ;
            c_ST_REQ: begin
                if (imem_ack) begin
                    if (!w_flush && !w_slot_free) begin
                        w_state_nxt = c_ST_HOLD;
                    end
                end else if (w_flush) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_HOLD: begin
                if (w_flush || w_consume) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req        = 1'b0;
        next_pc         = pc_cur;
        w_out_load_mem  = 1'b0;
        w_out_load_skid = 1'b0;
        w_skid_wr       = 1'b0;
        w_pend_wr       = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_flush) begin
                        next_pc = w_target;
                    end
                end
                c_ST_REQ: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if (w_flush) begin
                            next_pc = w_target;
                        end else begin
                            next_pc        = pc_cur + 32'd4;
                            w_out_load_mem = w_slot_free;
                            w_skid_wr      = !w_slot_free;
                        end
                    end else begin
                        // Address must not move while the request is outstanding.
                        w_pend_wr = w_flush;
                    end
                end
                c_ST_HOLD: begin
                    if (w_flush) begin
                        next_pc = w_target;
                    end else begin
                        w_out_load_skid = w_consume;
                    end
                end
                c_ST_DRAIN: begin
                    imem_req  = 1'b1;
                    w_pend_wr = w_flush;
                    if (imem_ack) begin
                        next_pc = w_flush ? w_target : r_pend_pc;
                    end
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'd0;
            r_if_pc      <= 32'd0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_pend_pc    <= 32'd0;
        end else begin
            if (w_flush) begin
                r_if_valid <= 1'b0;
            end else if (w_out_load_mem) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc    <= pc_cur;
            end else if (w_out_load_skid) begin
                r_if_valid <= 1'b1;
                r_if_instr <= r_skid_instr;
                r_if_pc    <= r_skid_pc;
            end else if (w_consume) begin
                r_if_valid <= 1'b0;
            end

            if (w_flush) begin
                r_skid_valid <= 1'b0;
            end else if (w_skid_wr) begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= pc_cur;
            end else if (w_out_load_skid) begin
                r_skid_valid <= 1'b0;
            end

            if (w_pend_wr) begin
                r_pend_pc <= w_target;
            end
        end
    end

    // Skid occupancy is implied by HOLD; the flag is kept for visibility.
    logic w_unused_skid_valid;
    assign w_unused_skid_valid = r_skid_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Scoreboard bench for fetch_ctrl with a PC register model and
//               a configurable-latency instruction memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] c_KEY      = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic        pc_en;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic        mem_ack;
    logic        late_ack;
    int          mem_wait;
    int          wcnt;
    logic        pend_req;
    logic [31:0] pend_addr;
    logic        sb_done;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];

    fetch_ctrl #(
        .RESET_PC(c_RESET_PC),
        .TRAP_VEC(c_TRAP_VEC)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pc_cur        (pc_cur),
        .pc_en         (pc_en),
        .next_pc       (next_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .trap          (trap),
        .stall         (stall),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // PC register: increments when not enabled.
    always @(posedge clk or posedge rst) begin
        if (rst)        pc_cur <= c_RESET_PC;
        else if (pc_en) pc_cur <= next_pc;
        else            pc_cur <= pc_cur + 32'd4;
    end

    assign imem_ack = mem_ack | late_ack;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory responder: acks after mem_wait idle request cycles.
    initial begin
        mem_ack    = 1'b0;
        imem_rdata = 32'd0;
        wcnt       = 0;
        pend_req   = 1'b0;
        pend_addr  = 32'd0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (pend_req) check_val("addr_stable", imem_addr, pend_addr);
                imem_rdata = imem_addr ^ c_KEY;
                if (wcnt >= mem_wait) begin
                    mem_ack  = 1'b1;
                    wcnt     = 0;
                    pend_req = 1'b0;
                end else begin
                    mem_ack   = 1'b0;
                    wcnt      = wcnt + 1;
                    pend_req  = 1'b1;
                    pend_addr = imem_addr;
                end
            end else begin
                mem_ack  = 1'b0;
                wcnt     = 0;
                pend_req = 1'b0;
            end
        end
    end

    // Scoreboard: every decode consume must match the next expected PC.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!sb_done && if_valid && !stall) begin
                check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("sb_if_pc", if_pc, e);
                    check_val("sb_if_instr", if_instr, e ^ c_KEY);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sb_done  = 1'b0;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        trap = 1'b0; late_ack = 1'b0; mem_wait = 0;

        repeat (3) @(negedge clk);
        #2;
        check_val("rst_if_valid", 32'(if_valid), 32'd0);
        check_val("rst_if_instr", if_instr, 32'd0);
        check_val("rst_if_pc", if_pc, 32'd0);
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_next_pc", next_pc, c_RESET_PC);

        for (int i = 0; i < 9; i++) exp_q.push_back(32'(4 * i));
        @(negedge clk); rst = 1'b0; #2;
        check_val("idle_no_req", 32'(imem_req), 32'd0);
        @(negedge clk); #2;
        check_val("first_req", 32'(imem_req), 32'd1);
        check_val("first_addr", imem_addr, c_RESET_PC);
        check_val("first_next_pc", next_pc, 32'd4);
        check_val("first_pc_en", 32'(pc_en), 32'd1);
        @(negedge clk); #2;
        check_val("fetch_latency", 32'(if_valid), 32'd1);
        repeat (5) @(negedge clk);

        // Stall three cycles: one word goes to the skid, request drops.
        @(negedge clk); stall = 1'b1; #2;
        check_val("skid_ack_req", 32'(imem_req), 32'd1);
        @(negedge clk); #2;
        check_val("hold_req", 32'(imem_req), 32'd0);
        check_val("hold_if_pc", if_pc, 32'd24);
        @(negedge clk); #2;
        check_val("hold_req2", 32'(imem_req), 32'd0);
        @(negedge clk); stall = 1'b0; #2;
        check_val("hold_release_pc", if_pc, 32'd24);
        @(negedge clk); #2;
        check_val("skid_out_pc", if_pc, 32'd28);
        check_val("resume_addr", imem_addr, 32'd32);
        #1 mem_wait = 3;

        // Redirect in the first wait cycle of a slow fetch.
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; #2;
        check_val("redir_next_pc", next_pc, 32'd36);
        exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
        @(negedge clk); redirect_valid = 1'b0; #2;
        check_val("drain_valid", 32'(if_valid), 32'd0);
        check_val("drain_addr", imem_addr, 32'd36);
        check_val("drain_req", 32'(imem_req), 32'd1);
        @(negedge clk); #2;
        check_val("drain_valid2", 32'(if_valid), 32'd0);
        @(negedge clk); #2;
        check_val("drain_ack_next_pc", next_pc, 32'h40);
        check_val("drain_valid3", 32'(if_valid), 32'd0);
        @(negedge clk); #2;
        check_val("redir_addr", imem_addr, 32'h40);
        check_val("redir_valid", 32'(if_valid), 32'd0);
        repeat (2) @(negedge clk);
        #2 check_val("redir_wait_valid", 32'(if_valid), 32'd0);
        @(negedge clk); #2;
        check_val("redir_ack_valid", 32'(if_valid), 32'd0);
        #1 mem_wait = 0;
        @(negedge clk); #2;
        check_val("redir_arrive", 32'(if_valid), 32'd1);
        @(negedge clk);

        // Trap and redirect together with an ack: trap wins, word dropped.
        @(negedge clk); trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; #2;
        check_val("trap_next_pc", next_pc, c_TRAP_VEC);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        @(negedge clk); trap = 1'b0; redirect_valid = 1'b0; #2;
        check_val("trap_addr", imem_addr, c_TRAP_VEC);
        check_val("trap_valid", 32'(if_valid), 32'd0);
        @(negedge clk);

        // Wrap-around at the top of the address space.
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #2;
        check_val("wrap_redir_next_pc", next_pc, 32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        @(negedge clk); redirect_valid = 1'b0; #2;
        check_val("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk); #2;
        check_val("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        check_val("wrap_next_pc", next_pc, 32'h0);
        @(negedge clk); #2;
        check_val("wrap_addr2", imem_addr, 32'h0);
        check_val("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        #1 mem_wait = 5;

        // Reset during an outstanding request, with acks during/after reset.
        @(negedge clk); #2;
        check_val("mid_req", 32'(imem_req), 32'd1);
        check_val("mid_addr", imem_addr, 32'd4);
        @(negedge clk); rst = 1'b1; #2;
        check_val("mid_rst_valid", 32'(if_valid), 32'd0);
        check_val("mid_rst_instr", if_instr, 32'd0);
        check_val("mid_rst_pc", if_pc, 32'd0);
        check_val("mid_rst_req", 32'(imem_req), 32'd0);
        check_val("mid_rst_next_pc", next_pc, c_RESET_PC);
        @(negedge clk); late_ack = 1'b1; #2;
        check_val("late_ack_next_pc", next_pc, c_RESET_PC);
        check_val("late_ack_valid", 32'(if_valid), 32'd0);
        #1 mem_wait = 0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd4);
        @(negedge clk); rst = 1'b0; #2;
        check_val("idle_ack_req", 32'(imem_req), 32'd0);
        check_val("idle_ack_next_pc", next_pc, c_RESET_PC);
        @(negedge clk); late_ack = 1'b0; #2;
        check_val("restart_req", 32'(imem_req), 32'd1);
        check_val("restart_addr", imem_addr, c_RESET_PC);
        @(negedge clk); #2;
        check_val("restart_valid", 32'(if_valid), 32'd1);
        @(negedge clk);
        @(negedge clk); stall = 1'b1;
        repeat (3) @(negedge clk);
        sb_done = 1'b1;
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
